// File: rtl/seg7_scan_capture.sv
// Receive side of a 4-digit multiplexed seven-segment link: debounces each anode/segment
// pattern, decodes it to BCD and assembles 4-digit frames. Define SEG7_CAP_TIMEOUT_EN for link_lost.
module seg7_scan_capture #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an_n,
   input  logic [6:0]  seg_n,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic [3:0]  seen,
   output logic        err_pulse,
   output logic [7:0]  err_cnt,
   output logic        link_lost
);

   localparam int RW = $clog2(STABLE_CYCLES + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

   logic [3:0]       an_q;
   logic [6:0]       seg_q;
   logic [RW-1:0]    run_q, run_d;
   logic [3:0][3:0]  staged_q, staged_d;
   logic [3:0]       sel, seen_all;
   logic [1:0]       idx;
   logic [3:0]       cap_digit;
   logic             legal, same, capture, cap_err, complete, timeout;

   function automatic logic [3:0] seg_decode(input logic [6:0] act);
      logic [3:0] d;
      case (act)
         7'b1111110: d = 4'd0;
         7'b0110000: d = 4'd1;
         7'b1101101: d = 4'd2;
         7'b1111001: d = 4'd3;
         7'b0110011: d = 4'd4;
         7'b1011011: d = 4'd5;
         7'b1011111: d = 4'd6;
         7'b1110000: d = 4'd7;
         7'b1111111: d = 4'd8;
         7'b1111011: d = 4'd9;
         7'b0000000: d = 4'hF;
         default:    d = 4'hE;
      endcase
      return d;
   endfunction

   assign sel   = ~an_n;
   assign legal = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
   assign same  = ({an_n, seg_n} == {an_q, seg_q});

   // Run length counts the current edge, so a fresh pattern starts at 1.
   always_comb begin
      run_d = '0;
      if (legal) begin
         if (!same)                run_d = RW'(1);
         else if (run_q != RUN_MAX) run_d = run_q + RW'(1);
         else                       run_d = run_q;
      end
   end

   // Capture only on the transition into RUN_MAX, not while parked there.
   assign capture   = legal && (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));
   assign cap_digit = seg_decode(~seg_n);
   assign cap_err   = capture && (cap_digit == 4'hE);

   always_comb begin
      case (sel)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   always_comb begin
      staged_d = staged_q;
      if (capture) staged_d[idx] = cap_digit;
   end

   assign seen_all = seen | (capture ? sel : 4'd0);
   assign complete = capture && (seen_all == 4'hF);

`ifdef SEG7_CAP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] IDLE_PRE = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_q;

   assign timeout = !capture && (idle_q == IDLE_PRE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_q    <= '0;
         link_lost <= 1'b0;
      end else if (capture) begin
         idle_q    <= '0;
         link_lost <= 1'b0;
      end else begin
         if (idle_q != IDLE_MAX) idle_q <= idle_q + TW'(1);
         if (timeout)            link_lost <= 1'b1;
      end
   end
`else
   assign timeout   = 1'b0;
   assign link_lost = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q        <= 4'hF;
         seg_q       <= 7'h7F;
         run_q       <= '0;
         staged_q    <= '0;
         value       <= '0;
         frame_valid <= 1'b0;
         seen        <= '0;
         err_pulse   <= 1'b0;
         err_cnt     <= '0;
      end else begin
         an_q        <= an_n;
         seg_q       <= seg_n;
         run_q       <= run_d;
         staged_q    <= staged_d;
         frame_valid <= complete;
         err_pulse   <= cap_err;
         if (cap_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (complete) begin
            value <= staged_d;
            seen  <= '0;
         end else if (timeout) begin
            seen  <= '0;
         end else begin
            seen  <= seen_all;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized and directed bench for seg7_scan_capture against a history-window reference model.
module tb_seg7_scan_capture;

   localparam int S = 4;
   localparam int T = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  an_n = 4'hF;
   logic [6:0]  seg_n = 7'h7F;
   logic [15:0] value;
   logic        frame_valid;
   logic [3:0]  seen;
   logic        err_pulse;
   logic [7:0]  err_cnt;
   logic        link_lost;

   seg7_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .an_n(an_n), .seg_n(seg_n), .value(value),
      .frame_valid(frame_valid), .seen(seen), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .link_lost(link_lost));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
   logic [6:0] bad_seg = ~7'b1001001;

   // ---------------- reference model ----------------
   logic [10:0] hist [S+1];
   logic [3:0]  m_staged [4];
   logic [3:0]  m_seen;
   logic [15:0] m_value;
   logic        m_fv, m_ep, m_lost;
   int          m_err, m_idle;

   function automatic bit legal_an(input logic [3:0] a);
      return $countones(~a) == 1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= S; i++) hist[i] = 11'h7FF;
         for (int i = 0; i < 4; i++) m_staged[i] = 4'd0;
         m_seen = 0; m_value = 0; m_fv = 0; m_ep = 0; m_err = 0; m_idle = 0; m_lost = 0;
      end else begin
         bit cap;
         logic [6:0] act;
         logic [3:0] d;
         int p;
         for (int i = S; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {an_n, seg_n};
         // captured when the newest S samples agree and the sample before them does not extend the run
         cap = legal_an(hist[0][10:7]);
         for (int i = 1; i < S; i++) if (hist[i] != hist[0]) cap = 0;
         if (legal_an(hist[S][10:7]) && hist[S] == hist[0]) cap = 0;
         m_fv = 0; m_ep = 0;
         if (cap) begin
            act = ~hist[0][6:0];
            d = (act == 7'd0) ? 4'hF : 4'hE;
            for (int k = 0; k < 10; k++) if (act == pat[k]) d = 4'(k);
            if (d == 4'hE) begin m_ep = 1; if (m_err < 255) m_err++; end
            p = 0;
            for (int k = 0; k < 4; k++) if (!hist[0][7+k]) p = k;
            m_staged[p] = d;
            m_seen[p] = 1'b1;
            if (m_seen == 4'hF) begin
               m_value = {m_staged[3], m_staged[2], m_staged[1], m_staged[0]};
               m_fv = 1; m_seen = 0;
            end
         end
`ifdef SEG7_CAP_TIMEOUT_EN
         if (cap) begin m_idle = 0; m_lost = 0; end
         else begin
            m_idle++;
            if (m_idle == T) begin m_lost = 1; m_seen = 0; end
         end
`endif
      end
   end

   int fv_dut = 0, fv_exp = 0, ep_dut = 0, ep_exp = 0, both_dut = 0;
   always @(negedge clk) begin
      if (frame_valid) fv_dut++;
      if (err_pulse) ep_dut++;
      if (frame_valid && err_pulse) both_dut++;
      if (m_fv) fv_exp++;
      if (m_ep) ep_exp++;
   end

   // Called at a negedge; returns at a negedge after n sampling edges.
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n = a; seg_n = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      int f0, e0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (value !== 16'h0) begin n_fail++; $display("FAIL rst_value got %h want 0", value); end
      n_cmp++; if (frame_valid !== 1'b0 || err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got %b%b want 00", frame_valid, err_pulse); end
      n_cmp++; if (seen !== 4'h0) begin n_fail++; $display("FAIL rst_seen got %h want 0", seen); end
      n_cmp++; if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_err_cnt got %h want 0", err_cnt); end
      n_cmp++; if (link_lost !== 1'b0) begin n_fail++; $display("FAIL rst_link_lost got %b want 0", link_lost); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      f0 = fv_dut; e0 = ep_dut;
      hold(4'hF, 7'h7F, 10);
      n_cmp++; if (fv_dut - f0 != 0 || ep_dut - e0 != 0) begin n_fail++; $display("FAIL idle_pulses got fv=%0d ep=%0d want 0 0", fv_dut - f0, ep_dut - e0); end
   endtask

   task automatic test_scan();
      int f0, k_fv;
      f0 = fv_dut;
      hold(4'b0111, ~pat[0], 8);
      hold(4'b1011, ~pat[1], 8);
      hold(4'b1101, ~pat[2], 8);
      an_n = 4'b1110; seg_n = ~pat[3];
      k_fv = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (frame_valid && k_fv == 0) k_fv = k;
      end
      n_cmp++; if (k_fv != S) begin n_fail++; $display("FAIL scan_latency got %0d want %0d", k_fv, S); end
      n_cmp++; if (fv_dut - f0 != 1) begin n_fail++; $display("FAIL scan_frames got %0d want 1", fv_dut - f0); end
      n_cmp++; if (value !== 16'h0123 || value !== m_value) begin n_fail++; $display("FAIL scan_value got %h want 0123 (model %h)", value, m_value); end
      n_cmp++; if (err_cnt !== 8'd0 || seen !== 4'd0) begin n_fail++; $display("FAIL scan_state got err=%0d seen=%b want 0 0000", err_cnt, seen); end
   endtask

   task automatic test_drop_and_midreset();
      int f0;
      f0 = fv_dut;
      hold(4'b0111, ~pat[0], 8);
      hold(4'b1011, ~pat[1], 3);
      hold(4'b1101, ~pat[2], 8);
      hold(4'b1110, ~pat[3], 8);
      n_cmp++; if (seen !== 4'b1011 || seen !== m_seen) begin n_fail++; $display("FAIL drop_seen got %b want 1011 (model %b)", seen, m_seen); end
      n_cmp++; if (fv_dut - f0 != 0) begin n_fail++; $display("FAIL drop_frames got %0d want 0", fv_dut - f0); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (seen !== 4'd0 || value !== 16'd0 || frame_valid !== 1'b0) begin n_fail++; $display("FAIL midreset got seen=%b value=%h fv=%b want 0 0 0", seen, value, frame_valid); end
      @(negedge clk);
      reset = 1'b0;
      n_cmp++; if (fv_dut - f0 != 0) begin n_fail++; $display("FAIL midreset_frames got %0d want 0", fv_dut - f0); end
   endtask

   task automatic test_error();
      int e0, b0;
      e0 = ep_dut;
      hold(4'b1110, bad_seg, 6);
      n_cmp++; if (ep_dut - e0 != 1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL err_one got pulses=%0d cnt=%0d want 1 1", ep_dut - e0, err_cnt); end
      hold(4'b1110, 7'h7F, 6);
      n_cmp++; if (ep_dut - e0 != 1) begin n_fail++; $display("FAIL blank_no_err got pulses=%0d want 1", ep_dut - e0); end
      hold(4'b0111, ~pat[0], 6);
      hold(4'b1011, ~pat[1], 6);
      hold(4'b1101, ~pat[2], 6);
      n_cmp++; if (value !== 16'h012F || value !== m_value) begin n_fail++; $display("FAIL blank_value got %h want 012f (model %h)", value, m_value); end
      // error capture that also completes the frame
      b0 = both_dut;
      hold(4'b0111, ~pat[7], 6);
      hold(4'b1011, ~pat[8], 6);
      hold(4'b1101, ~pat[9], 6);
      hold(4'b1110, bad_seg, 6);
      n_cmp++; if (both_dut - b0 != 1) begin n_fail++; $display("FAIL err_frame_same_cycle got %0d want 1", both_dut - b0); end
      n_cmp++; if (value !== 16'h789E || err_cnt !== 8'd2) begin n_fail++; $display("FAIL err_frame got value=%h cnt=%0d want 789e 2", value, err_cnt); end
   endtask

   task automatic test_illegal_an();
      int f0, e0;
      logic [3:0] s0;
      hold(4'b0111, ~pat[5], 6);
      s0 = m_seen;
      f0 = fv_dut; e0 = ep_dut;
      hold(4'b0011, ~pat[1], 20);
      hold(4'b1111, ~pat[1], 20);
      hold(4'b0000, bad_seg, 8);
      n_cmp++; if (seen !== 4'b1000 || seen !== s0) begin n_fail++; $display("FAIL illegal_seen got %b want 1000", seen); end
      n_cmp++; if (fv_dut - f0 != 0 || ep_dut - e0 != 0) begin n_fail++; $display("FAIL illegal_pulses got fv=%0d ep=%0d want 0 0", fv_dut - f0, ep_dut - e0); end
   endtask

   task automatic test_timeout();
      logic [15:0] v0;
      hold(4'b0111, ~pat[4], 8);
      v0 = value;
      hold(4'hF, 7'h7F, 70);
`ifdef SEG7_CAP_TIMEOUT_EN
      n_cmp++; if (link_lost !== 1'b1 || seen !== 4'd0) begin n_fail++; $display("FAIL timeout_set got lost=%b seen=%b want 1 0000", link_lost, seen); end
      n_cmp++; if (value !== v0 || m_lost !== 1'b1) begin n_fail++; $display("FAIL timeout_value got %h want %h", value, v0); end
      hold(4'b1011, ~pat[6], 4);
      n_cmp++; if (link_lost !== 1'b0 || seen !== 4'b0100) begin n_fail++; $display("FAIL timeout_clear got lost=%b seen=%b want 0 0100", link_lost, seen); end
`else
      n_cmp++; if (link_lost !== 1'b0 || seen !== m_seen) begin n_fail++; $display("FAIL no_timeout got lost=%b seen=%b want 0 %b", link_lost, seen, m_seen); end
      n_cmp++; if (value !== v0) begin n_fail++; $display("FAIL no_timeout_value got %h want %h", value, v0); end
`endif
   endtask

   task automatic test_random();
      logic [3:0] a;
      logic [6:0] s;
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         case ($urandom_range(0, 3))
            0: a = 4'b0111; 1: a = 4'b1011; 2: a = 4'b1101; default: a = 4'b1110;
         endcase
         if ($urandom_range(0, 9) == 0) a = 4'($urandom);
         s = ~pat[r];
         if ($urandom_range(0, 9) == 0) s = 7'h7F;
         if ($urandom_range(0, 14) == 0) s = 7'($urandom);
         hold(a, s, $urandom_range(1, 7));
         if (i % 80 == 79) begin
            n_cmp++; if (value !== m_value || seen !== m_seen || err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL rand_state@%0d got %h/%b/%0d want %h/%b/%0d", i, value, seen, err_cnt, m_value, m_seen, m_err); end
         end
      end
      n_cmp++; if (fv_dut != fv_exp || ep_dut != ep_exp) begin n_fail++; $display("FAIL rand_pulses got fv=%0d ep=%0d want %0d %0d", fv_dut, ep_dut, fv_exp, ep_exp); end
      n_cmp++; if (link_lost !== m_lost) begin n_fail++; $display("FAIL rand_link_lost got %b want %b", link_lost, m_lost); end
   endtask

   task automatic test_err_saturate();
      for (int i = 0; i < 260; i++) begin
         hold(4'b1110, bad_seg, 4);
         hold(4'b1110, 7'h7F, 4);
      end
      n_cmp++; if (err_cnt !== 8'd255 || m_err != 255) begin n_fail++; $display("FAIL err_saturate got %0d want 255", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_drop_and_midreset();
      test_error();
      test_illegal_an();
      test_timeout();
      test_random();
      test_err_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
